mx_int8_bd_dequant: RTL

MX_INT8_BD_DEQUANT -- requirements
Module: mx_int8_bd_dequant

---
 rtl/mx_int8_bd_dequant_pkg.sv | 35 +++
 rtl/mx_int8_bd_dequant_elem2fp32.sv | 37 +++
 rtl/mx_int8_bd_dequant.sv | 77 +++++++
 3 files changed

// File: rtl/mx_int8_bd_dequant_pkg.sv
// mx_int8_bd_dequant_pkg: shared MXINT8 / scalar constants, FSM state type and a leading-one helper.
package mx_int8_bd_dequant_pkg;

  // MXINT8 block geometry
  localparam int BLK_SIZE = 32;
  localparam int ELEM_W   = 8;
  localparam int IDX_W    = $clog2(BLK_SIZE);
  localparam int BLK_W    = BLK_SIZE * ELEM_W;

  // E8M0 shared scale
  localparam int         E8M0_BIAS = 127;
  localparam logic [7:0] NAN_SCALE = 8'hFF;

  // int8 elements carry 6 fractional bits: value = X * 2^(S - bias - 6)
  localparam logic signed [9:0] INT8_FRAC = 10'sd6;

  // binary32 output format
  localparam int          FLOAT32_WIDTH = 32;
  localparam logic [31:0] CANON_NAN     = 32'h7FC0_0000;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_SIZE - 1);

  typedef enum logic {
    EMPTY,
    ACTIVE
  } state_t;

  // Bit position of the most significant set bit; 0 when m is 0.
  function automatic logic [2:0] lead_one(input logic [7:0] m);
    lead_one = '0;
    for (int i = 0; i < 8; i++)
      if (m[i]) lead_one = 3'(i);
  endfunction

endpackage

// File: rtl/mx_int8_bd_dequant_elem2fp32.sv
// mx_int8_elem2fp32: exact combinational conversion of one int8 element under an E8M0 scale to binary32.
//   scale_i : E8M0 shared scale (0xFF = NaN)
//   int8_i  : two's-complement element
//   fp32_o  : IEEE-754 binary32 result (normal, subnormal, +/-Inf or canonical NaN)
module mx_int8_elem2fp32
  import mx_int8_bd_dequant_pkg::*;
(
  input  logic [7:0]               scale_i,
  input  logic [ELEM_W-1:0]        int8_i,
  output logic [FLOAT32_WIDTH-1:0] fp32_o
);

  logic              sign;
  logic [7:0]        mag;
  logic [2:0]        p;
  logic signed [9:0] e;
  logic [23:0]       norm;
  logic [22:0]       sub;

  always_comb begin
    sign = int8_i[7];
    // -128 negates to 0x80, which is exactly the magnitude 128 we want
    mag  = sign ? 8'(-int8_i) : int8_i;
    p    = lead_one(mag);
    e    = $signed({2'b0, scale_i}) + $signed({7'b0, p}) - INT8_FRAC;
    // leading one lands on bit 23 so bits [22:0] are the left-aligned mantissa
    norm = {16'b0, mag} << (5'd23 - {2'b0, p});
    // subnormal only when scale <= 6, so the shift stays within 22 bits
    sub  = {15'b0, mag} << (scale_i[4:0] + 5'd16);
    fp32_o = scale_i == NAN_SCALE ? CANON_NAN
           : mag == 8'd0          ? '0
           : e >= 10'sd255        ? {sign, 8'hFF, 23'b0}
           : e <= 10'sd0          ? {sign, 8'h00, sub}
           :                        {sign, e[7:0], norm[22:0]};
  end

endmodule

// File: rtl/mx_int8_bd_dequant.sv
// mx_int8_bd_dequant: streams an accepted MXINT8 block out as 32 binary32 beats, one per cycle.
//   clk, rst_n   : clock, synchronous active-low reset
//   blk_valid_i  : block offered; blk_ready_o : block accepted on valid && ready
//   scale_i      : E8M0 shared scale; elem_i : 32 int8 elements, element k at [8k+7:8k]
//   out_valid_o  : fp32_o holds a valid element; out_ready_i : downstream accepts
//   fp32_o       : converted element; out_last_o : current element is element 31
module mx_int8_bd_dequant
  import mx_int8_bd_dequant_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     blk_valid_i,
  output logic                     blk_ready_o,
  input  logic [7:0]               scale_i,
  input  logic [BLK_W-1:0]         elem_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [FLOAT32_WIDTH-1:0] fp32_o,
  output logic                     out_last_o
);

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d, idx_nx;
  logic [7:0]               scale_q, scale_d;
  logic [BLK_W-1:0]         elem_q, elem_d;
  logic [FLOAT32_WIDTH-1:0] fp32_q, fp32_d;
  logic                     hs, at_last, accept, advance;
  logic [7:0]               cv_scale;
  logic [ELEM_W-1:0]        cv_elem;
  logic [FLOAT32_WIDTH-1:0] cv_fp32;

  // One converter serves both the first element of a new block (straight from
  // the inputs) and each following element (from the latched block).
  mx_int8_elem2fp32 u_conv (
    .scale_i (cv_scale),
    .int8_i  (cv_elem),
    .fp32_o  (cv_fp32)
  );

  always_comb begin
    out_valid_o = state_q == ACTIVE;
    at_last     = idx_q == LAST_IDX;
    out_last_o  = out_valid_o && at_last;
    hs          = out_valid_o && out_ready_i;
    // ready on the final handshake lets the next block follow with no bubble
    blk_ready_o = state_q == EMPTY || (hs && at_last);
    accept      = blk_valid_i && blk_ready_o;
    advance     = hs && !at_last;
    idx_nx      = idx_q + 1'b1;
    cv_scale    = accept ? scale_i : scale_q;
    cv_elem     = accept ? elem_i[ELEM_W-1:0] : elem_q[{idx_nx, 3'b0} +: ELEM_W];
    state_d     = accept ? ACTIVE : (hs && at_last) ? EMPTY : state_q;
    idx_d       = accept ? '0 : advance ? idx_nx : idx_q;
    scale_d     = accept ? scale_i : scale_q;
    elem_d      = accept ? elem_i : elem_q;
    fp32_d      = (accept || advance) ? cv_fp32 : fp32_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      idx_q   <= '0;
      scale_q <= '0;
      elem_q  <= '0;
      fp32_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      scale_q <= scale_d;
      elem_q  <= elem_d;
      fp32_q  <= fp32_d;
    end
  end

  assign fp32_o = fp32_q;

endmodule
